// File: rtl/sensor_ctrl.sv
// sensor_ctrl: captures 32-bit sensor samples into a DEPTH-word buffer that the CPU
// reads through a registered port. A buffer-full interrupt is raised when the last
// word is written, and further samples are dropped until the CPU clears the buffer.
// Optional feature macro: SCTRL_OVERRUN_CNT_EN adds a saturating 8-bit count of
// samples dropped while the buffer is full. Without it, sctrl_overrun is tied to zero.
module sensor_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          sctrl_en,
    input  logic          sctrl_clear,
    input  logic [AW-1:0] sctrl_addr,
    output logic [31:0]   sctrl_out,
    output logic          sctrl_interrupt,
    output logic          sensor_en,
    input  logic          sensor_ready,
    input  logic [31:0]   sensor_out,
    output logic [7:0]    sctrl_overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic          interrupt_q;
    logic [31:0]   rd_data_q;
    logic [31:0]   mem_q [DEPTH];

    logic          wr_en;
    logic          last_write;

    // Samples are requested only while collecting. A clear in the same cycle wins over
    // the strobe, so that sample is dropped.
    assign sensor_en  = (state_q == COLLECT);
    assign wr_en      = sensor_en && sensor_ready && !sctrl_clear;
    assign last_write = wr_en && (wr_ptr_q == AW'(DEPTH - 1));

    // Capture FSM with its write pointer and registered interrupt. The interrupt rises on
    // the same edge that enters FULL, so it is visible in the cycle after the final strobe.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            interrupt_q <= 1'b0;
        end else if (sctrl_clear) begin
            wr_ptr_q    <= '0;
            interrupt_q <= 1'b0;
            state_q     <= sctrl_en ? COLLECT : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sctrl_en) begin
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                    if (last_write) begin
                        state_q     <= FULL;
                        interrupt_q <= 1'b1;
                    end else if (!sctrl_en) begin
                        state_q <= IDLE;
                    end
                end
                FULL: begin
                    state_q <= FULL;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The sample buffer has no reset. Its contents survive clear and pause, and they are
    // simply undefined after a reset.
    always_ff @(posedge cpu_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sensor_out;
        end
    end

    // Registered CPU read port. Reading the array before this edge's write lands means a
    // same-address read returns the old word.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[sctrl_addr];
        end
    end

    assign sctrl_out       = rd_data_q;
    assign sctrl_interrupt = interrupt_q;

`ifdef SCTRL_OVERRUN_CNT_EN
    logic [7:0] overrun_q;

    // Count strobes that arrive while the buffer is full. The count saturates at 0xFF
    // and a clear resets it.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            overrun_q <= 8'h00;
        end else if (sctrl_clear) begin
            overrun_q <= 8'h00;
        end else if ((state_q == FULL) && sensor_ready && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    assign sctrl_overrun = overrun_q;
`else
    assign sctrl_overrun = 8'h00;
`endif

endmodule

// File: tb/tb_sensor_ctrl.sv
// tb_sensor_ctrl: directed bench for sensor_ctrl. Every cycle's read address pushes the
// word the buffer model says should come back, and the registered read data is popped
// and compared one cycle later.
module tb_sensor_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef struct {
        bit          vld;
        logic [31:0] val;
    } exp_t;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst;
    logic          sctrl_en;
    logic          sctrl_clear;
    logic [AW-1:0] sctrl_addr;
    logic [31:0]   sctrl_out;
    logic          sctrl_interrupt;
    logic          sensor_en;
    logic          sensor_ready;
    logic [31:0]   sensor_out;
    logic [7:0]    sctrl_overrun;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelMem [DEPTH];
    bit          modelVld [DEPTH];
    int          expPtr;
    logic [7:0]  expOverrun;
    exp_t        sbQ [$];

    sensor_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .cpu_clk         (cpu_clk),
        .cpu_rst         (cpu_rst),
        .sctrl_en        (sctrl_en),
        .sctrl_clear     (sctrl_clear),
        .sctrl_addr      (sctrl_addr),
        .sctrl_out       (sctrl_out),
        .sctrl_interrupt (sctrl_interrupt),
        .sensor_en       (sensor_en),
        .sensor_ready    (sensor_ready),
        .sensor_out      (sensor_out),
        .sctrl_overrun   (sctrl_overrun)
    );

    // Free-running 100 MHz clock
    always #5 cpu_clk = ~cpu_clk;

    // Hard time limit so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s observed=empty-scoreboard expected=entry", tag);
        end else begin
            e = sbQ.pop_front();
            if (e.vld) begin
                check(tag, sctrl_out, e.val);
            end
        end
    endtask

    // One clock of stimulus. The read address pushes the model's current (pre-write) word.
    // An accepted strobe updates the model at the expected write pointer.
    task automatic applyStimulus(input logic rdy, input logic [31:0] data,
                                 input logic [AW-1:0] addr, input bit accept,
                                 input string tag);
        exp_t e;
        sensor_ready = rdy;
        sensor_out   = data;
        sctrl_addr   = addr;
        e.vld = modelVld[addr];
        e.val = modelMem[addr];
        sbQ.push_back(e);
        if (accept) begin
            modelMem[expPtr] = data;
            modelVld[expPtr] = 1'b1;
            expPtr = (expPtr + 1) % DEPTH;
        end
        tick();
        checkOutput(tag);
        sensor_ready = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_out"},  sctrl_out, 32'h0);
        check({tag, "_intr"}, 32'(sctrl_interrupt), 32'h0);
        check({tag, "_sen"},  32'(sensor_en), 32'h0);
        check({tag, "_ovr"},  32'(sctrl_overrun), 32'h0);
    endtask

    initial begin
`ifdef SCTRL_OVERRUN_CNT_EN
        expOverrun = 8'hFF;
`else
        expOverrun = 8'h00;
`endif
        cpu_rst      = 1'b1;
        sctrl_en     = 1'b0;
        sctrl_clear  = 1'b0;
        sctrl_addr   = '0;
        sensor_ready = 1'b0;
        sensor_out   = '0;
        expPtr       = 0;
        for (int i = 0; i < DEPTH; i++) modelVld[i] = 1'b0;

        #2;
        checkAllZero("reset");
        tick();
        tick();
        cpu_rst = 1'b0;

        $display("[TB] fill 64 samples");
        sctrl_en = 1'b1;
        applyStimulus(1'b0, 32'h0, '0, 1'b0, "idle_rd");
        check("collect_sensor_en", 32'(sensor_en), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i), AW'(i == 0 ? 0 : i - 1), 1'b1, "fill_rd");
            if (i == DEPTH - 2) check("intr_before_last", 32'(sctrl_interrupt), 32'h0);
        end
        check("fill_intr", 32'(sctrl_interrupt), 32'h1);
        check("fill_sensor_en", 32'(sensor_en), 32'h0);
        applyStimulus(1'b0, 32'h0, AW'(5), 1'b0, "fill_addr5");

        $display("[TB] 300 strobes while full");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, $urandom, AW'(i % DEPTH), 1'b0, "full_rd");
        end
        check("overrun_count", 32'(sctrl_overrun), 32'(expOverrun));
        check("full_intr_hold", 32'(sctrl_interrupt), 32'h1);
        check("full_sensor_en", 32'(sensor_en), 32'h0);

        $display("[TB] clear collides with strobe");
        sctrl_clear = 1'b1;
        expPtr = 0;
        applyStimulus(1'b1, 32'hDEAD, '0, 1'b0, "clear_rd0");
        sctrl_clear = 1'b0;
        check("clear_intr", 32'(sctrl_interrupt), 32'h0);
        check("clear_overrun", 32'(sctrl_overrun), 32'h0);
        check("clear_to_collect", 32'(sensor_en), 32'h1);
        applyStimulus(1'b0, 32'h0, '0, 1'b0, "clear_addr0_old");
        applyStimulus(1'b1, 32'hA5A5_0000, AW'(1), 1'b1, "clear_first_wr");
        applyStimulus(1'b0, 32'h0, '0, 1'b0, "clear_wrptr_zero");

        $display("[TB] pause and resume");
        sctrl_clear = 1'b1;
        sctrl_en = 1'b0;
        expPtr = 0;
        applyStimulus(1'b0, 32'h0, '0, 1'b0, "clr_idle");
        sctrl_clear = 1'b0;
        check("clr_idle_sensor_en", 32'(sensor_en), 32'h0);
        sctrl_en = 1'b1;
        applyStimulus(1'b0, 32'h0, '0, 1'b0, "pause_start");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'(i), AW'(20), 1'b1, "pause_fill_rd");
        end
        sctrl_en = 1'b0;
        applyStimulus(1'b0, 32'h0, AW'(9), 1'b0, "pause_rd9");
        check("pause_sensor_en", 32'(sensor_en), 32'h0);
        for (int j = 0; j < 20; j++) begin
            applyStimulus((j % 3) == 0, 32'h0BAD, AW'(j % 16), 1'b0, "pause_idle_rd");
        end
        check("pause_intr", 32'(sctrl_interrupt), 32'h0);
        sctrl_en = 1'b1;
        applyStimulus(1'b0, 32'h0, AW'(10), 1'b0, "resume_rd10_old");
        check("resume_sensor_en", 32'(sensor_en), 32'h1);
        for (int i = 0; i < 54; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i), AW'(9), 1'b1, "resume_rd9");
        end
        check("resume_intr", 32'(sctrl_interrupt), 32'h1);
        applyStimulus(1'b0, 32'h0, AW'(10), 1'b0, "resume_addr10");
        applyStimulus(1'b0, 32'h0, AW'(63), 1'b0, "resume_addr63");

        $display("[TB] read/write collision");
        sctrl_clear = 1'b1;
        expPtr = 0;
        applyStimulus(1'b0, 32'h0, '0, 1'b0, "rw_clear");
        sctrl_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h2000 + 32'(i), AW'(40), 1'b1, "rw_pre");
        end
        applyStimulus(1'b1, 32'h2003, AW'(3), 1'b1, "rw_old_data");
        applyStimulus(1'b0, 32'h0, AW'(3), 1'b0, "rw_new_data");

        $display("[TB] reset mid-fill");
        sctrl_clear = 1'b1;
        expPtr = 0;
        applyStimulus(1'b0, 32'h0, '0, 1'b0, "rst_clear");
        sctrl_clear = 1'b0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 32'h3000 + 32'(i), AW'(0), 1'b1, "rst_pre_rd");
        end
        #2;
        cpu_rst = 1'b1;
        #1;
        checkAllZero("midfill_reset");
        for (int i = 0; i < DEPTH; i++) modelVld[i] = 1'b0;
        expPtr = 0;
        tick();
        cpu_rst = 1'b0;
        applyStimulus(1'b0, 32'h0, '0, 1'b0, "refill_start");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h4000 + 32'(i), AW'(i == 0 ? 0 : i - 1), 1'b1, "refill_rd");
        end
        check("refill_intr", 32'(sctrl_interrupt), 32'h1);
        applyStimulus(1'b0, 32'h0, AW'(0), 1'b0, "refill_addr0");
        #2;
        cpu_rst = 1'b1;
        #1;
        checkAllZero("full_reset");
        tick();
        cpu_rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_ctrl.md
SENSOR_CTRL -- requirements
Module: sensor_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit sample words buffered (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 6, buffer address width, equal to log2(DEPTH).
REQ-003 SHALL have port cpu_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port cpu_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port sctrl_en  input  1  CPU enable for sample capture.
REQ-006 SHALL have port sctrl_clear  input  1  CPU request to empty the buffer and drop the interrupt.
REQ-007 SHALL have port sctrl_addr  input  AW  CPU read address into the buffer.
REQ-008 SHALL have port sctrl_out  output  32  CPU read data.
REQ-009 SHALL have port sctrl_interrupt  output  1  buffer-full interrupt to the CPU.
REQ-010 SHALL have port sensor_en  output  1  request for samples to the external sensor.
REQ-011 SHALL have port sensor_ready  input  1  one-cycle strobe meaning sensor_out is valid.
REQ-012 SHALL have port sensor_out  input  32  sample data, valid only while sensor_ready=1.
REQ-013 SHALL have port sctrl_overrun  output  8  count of dropped samples (see Configuration).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, COLLECT and FULL.
REQ-015 SHALL, in IDLE, drive sensor_en=0 and move to COLLECT on the next edge when sctrl_en=1 and sctrl_clear=0.
REQ-016 SHALL, in COLLECT, drive sensor_en=1 combinationally from the state.
REQ-017 SHALL, in COLLECT with sensor_ready=1, write sensor_out to buffer[wr_ptr] and increment wr_ptr.
REQ-018 SHALL move from COLLECT to FULL when a sample is written at wr_ptr=DEPTH-1; wr_ptr wraps to 0 and that is the last accepted sample.
REQ-019 SHALL hold sctrl_interrupt=1 (registered) from the cycle after entering FULL until cleared.
REQ-020 SHALL, in FULL, drive sensor_en=0 and discard every sensor_ready strobe without writing the buffer.
REQ-021 SHALL, when sctrl_en falls in COLLECT, go to IDLE on the next edge and keep wr_ptr and the buffer contents; a later re-enable resumes at the same wr_ptr.
REQ-022 SHALL, on sctrl_clear=1 in any state, set wr_ptr=0 and sctrl_interrupt=0 on that edge, then go to COLLECT if sctrl_en=1, else to IDLE.
REQ-023 SHALL give sctrl_clear priority over a simultaneous sensor_ready, so that strobe is dropped.
REQ-024 SHALL ignore sensor_ready whenever sensor_en=0.
REQ-025 SHALL register sctrl_out <= buffer[sctrl_addr] every cycle, giving 1-cycle read latency.
REQ-026 SHALL return the pre-write data on sctrl_out when a read and a write hit the same address in the same cycle.
REQ-027 SHALL not clear buffer contents on sctrl_clear; only wr_ptr and the interrupt are reset.

Reset
REQ-028 SHALL, while cpu_rst=1, immediately force state=IDLE, wr_ptr=0, sctrl_interrupt=0, sensor_en=0, sctrl_out=0 and sctrl_overrun=0.
REQ-029 SHALL abandon any in-progress fill when reset is asserted mid-operation; buffer contents are undefined after reset and need not be cleared.

Configuration
REQ-030 SHALL, when macro SCTRL_OVERRUN_CNT_EN is defined, include an 8-bit counter driving sctrl_overrun.
REQ-031 SHALL increment that counter, saturating at 8'hFF, for each sensor_ready strobe received in FULL.
REQ-032 SHALL reset that counter to 0 on sctrl_clear.
REQ-033 SHALL, when SCTRL_OVERRUN_CNT_EN is undefined, tie sctrl_overrun to 8'h00 and synthesize no counter.

Verification
REQ-034 SHALL verify fill: sctrl_en=1, 64 strobes with data 0..63 -> sctrl_interrupt=1 one cycle after the 64th, sensor_en=0, reading addr 5 gives 32'd5 one cycle later.
REQ-035 SHALL verify pause: disable after 10 samples, wait 20 cycles, re-enable, send 54 samples -> interrupt fires, and addr 9=32'd9 and addr 10 holds the first post-resume sample.
REQ-036 SHALL verify clear collision: in FULL, sctrl_clear=1 together with sensor_ready=1 and data 32'hDEAD -> interrupt=0, wr_ptr=0, and addr 0 still holds its old value.
REQ-037 SHALL verify overrun with the macro on: 300 strobes in FULL -> sctrl_overrun=8'hFF; with the macro off -> sctrl_overrun=8'h00.
REQ-038 SHALL verify reset mid-fill: cpu_rst pulsed after 30 samples -> all outputs 0 at once, then a full 64-sample fill re-raises the interrupt.
REQ-039 SHALL verify read/write collision: read addr 3 in the same cycle as the 4th write -> sctrl_out shows the old data, and the new data on the following read.
